// File: rtl/systolic_array_sequencer_if.sv
// Host/array-side signal bundle for the systolic array tile sequencer.
// The master side drives requests and backpressure; the slave side is the sequencer.
interface systolic_array_sequencer_if #(
  parameter int ARR_SIZE = 4,
  parameter int K_W      = 16,
  parameter int CNT_W    = K_W + 2
);
  localparam int AW = $clog2(ARR_SIZE);

  logic                start;
  logic [K_W-1:0]      k_len;
  logic                hold;
  logic                abort;
  logic                busy;
  logic                done;
  logic                err;
  logic                array_mode;
  logic                array_en;
  logic                ld_en;
  logic [AW-1:0]       ld_addr;
  logic [ARR_SIZE-1:0] feed_mask;
  logic [ARR_SIZE-1:0] out_mask;
  logic [CNT_W-1:0]    step;

  modport master (
    output start, k_len, hold, abort,
    input  busy, done, err, array_mode, array_en, ld_en, ld_addr,
           feed_mask, out_mask, step
  );

  modport slave (
    input  start, k_len, hold, abort,
    output busy, done, err, array_mode, array_en, ld_en, ld_addr,
           feed_mask, out_mask, step
  );
endinterface

// File: rtl/systolic_array_sequencer.sv
// Tile sequencer: weight preload (LOAD), skewed activation streaming (COMPUTE), DONE pulse.
// Outputs decode registered state only; hold gates the enables and masks combinationally.
module systolic_array_sequencer #(
  parameter int ARR_SIZE = 4,
  parameter int K_W      = 16,
  parameter int CNT_W    = K_W + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  systolic_array_sequencer_if.slave bus
);
  localparam int AW = $clog2(ARR_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]    r_klen, w_klen_nxt;
  logic [CNT_W-1:0]    w_last;
  logic                r_err, w_err_nxt;
  logic                w_run;
  logic [ARR_SIZE-1:0] w_feed, w_out;

  assign w_run  = ~bus.hold;
  assign w_last = r_klen + CNT_W'(2 * ARR_SIZE - 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_klen  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_klen  <= w_klen_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_klen_nxt  = r_klen;
    w_err_nxt   = 1'b0;
    // abort also swallows a simultaneous start in IDLE (no err either)
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.k_len != '0) begin
              w_klen_nxt  = CNT_W'(bus.k_len);
              w_cnt_nxt   = '0;
              w_state_nxt = S_LOAD;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_run) begin
            if (r_cnt == CNT_W'(ARR_SIZE - 1)) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_COMPUTE;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (w_run) begin
            if (r_cnt == w_last) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_DONE;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Row r consumes at t in [r, r+k); column c emits at t in [ARR_SIZE+c, ARR_SIZE+c+k).
  always_comb begin
    w_feed = '0;
    w_out  = '0;
    for (int unsigned r = 0; r < ARR_SIZE; r++) begin
      w_feed[r] = (r_cnt >= CNT_W'(r)) && (r_cnt < CNT_W'(r) + r_klen);
      w_out[r]  = (r_cnt >= CNT_W'(ARR_SIZE + r)) &&
                  (r_cnt < CNT_W'(ARR_SIZE + r) + r_klen);
    end
  end

  always_comb begin
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.err        = r_err;
    bus.array_mode = 1'b0;
    bus.array_en   = 1'b0;
    bus.ld_en      = 1'b0;
    bus.ld_addr    = '0;
    bus.feed_mask  = '0;
    bus.out_mask   = '0;
    bus.step       = '0;
    case (r_state)
      S_LOAD: begin
        bus.busy       = 1'b1;
        bus.array_mode = 1'b1;
        bus.array_en   = w_run;
        bus.ld_en      = w_run;
        bus.ld_addr    = r_cnt[AW-1:0];
      end
      S_COMPUTE: begin
        bus.busy      = 1'b1;
        bus.array_en  = w_run;
        bus.step      = r_cnt;
        bus.feed_mask = w_run ? w_feed : '0;
        bus.out_mask  = w_run ? w_out : '0;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Directed bench for systolic_array_sequencer: per-cycle vector table plus a held k=5 tile run.
module tb_systolic_array_sequencer;
  localparam int N  = 4;
  localparam int KW = 16;
  localparam int CW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_array_sequencer_if #(.ARR_SIZE(N), .K_W(KW), .CNT_W(CW)) bus ();

  systolic_array_sequencer #(.ARR_SIZE(N), .K_W(KW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // expected packing: busy,done,err,mode,en,ld_en | ld_addr | feed | out | step
  typedef struct {
    logic          rst;
    logic          start;
    logic          hold;
    logic          abort;
    logic [KW-1:0] k;
    logic [33:0]   exp;
  } vec_t;

  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  f3[10];
  logic [3:0]  o3[10];
  logic [3:0]  f1[8];
  logic [3:0]  o1[8];
  logic [33:0] z = '0;

  function automatic logic [33:0] ex(logic busy, logic done, logic err, logic mode,
                                     logic en, logic ld, logic [1:0] addr,
                                     logic [3:0] feed, logic [3:0] outm, logic [17:0] step);
    return {busy, done, err, mode, en, ld, addr, feed, outm, step};
  endfunction

  function automatic logic [33:0] act();
    return {bus.busy, bus.done, bus.err, bus.array_mode, bus.array_en, bus.ld_en,
            bus.ld_addr, bus.feed_mask, bus.out_mask, bus.step};
  endfunction

  task automatic add(logic r, logic s, logic h, logic a, logic [KW-1:0] k, logic [33:0] e);
    vec_t v;
    v.rst = r; v.start = s; v.hold = h; v.abort = a; v.k = k; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic add_load();
    for (int a = 0; a < N; a++) add(0, 0, 0, 0, 0, ex(1, 0, 0, 1, 1, 1, 2'(a), 0, 0, 0));
  endtask

  task automatic check_vec(string name, logic [33:0] got, logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got ctl=%b addr=%0d feed=%b out=%b step=%0d, expected ctl=%b addr=%0d feed=%b out=%b step=%0d",
               name, got[33:28], got[27:26], got[25:22], got[21:18], got[17:0],
               exp[33:28], exp[27:26], exp[25:22], exp[21:18], exp[17:0]);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int n;
    int fsum;
    int osum;
    f3 = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    o3 = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
    f1 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    o1 = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8};

    // reset state, with start asserted under reset
    add(1, 1, 0, 0, 3, z);
    add(0, 0, 0, 0, 0, z);
    // k=3 tile; start during DONE must be ignored
    add(0, 1, 0, 0, 3, z);
    add_load();
    for (int t = 0; t < 10; t++) add(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 1, 0, 0, f3[t], o3[t], 18'(t)));
    add(0, 1, 0, 0, 3, ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, z);
    // k=3 tile with hold for three cycles at t=2
    add(0, 1, 0, 0, 3, z);
    add_load();
    for (int t = 0; t < 10; t++) begin
      if (t == 2)
        for (int h = 0; h < 3; h++) add(0, 0, 1, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
      add(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 1, 0, 0, f3[t], o3[t], 18'(t)));
    end
    add(0, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, z);
    // zero-length start
    add(0, 1, 0, 0, 0, z);
    add(0, 0, 0, 0, 0, ex(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, z);
    // abort together with start in IDLE
    add(0, 1, 0, 1, 5, z);
    add(0, 0, 0, 0, 0, z);
    // k=3 tile, one held LOAD cycle, aborted at t=5
    add(0, 1, 0, 0, 3, z);
    add(0, 0, 0, 0, 0, ex(1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, ex(1, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    for (int a = 1; a < N; a++) add(0, 0, 0, 0, 0, ex(1, 0, 0, 1, 1, 1, 2'(a), 0, 0, 0));
    for (int t = 0; t < 5; t++) add(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 1, 0, 0, f3[t], o3[t], 18'(t)));
    add(0, 0, 0, 1, 0, ex(1, 0, 0, 0, 1, 0, 0, f3[5], o3[5], 5));
    add(0, 0, 0, 0, 0, z);
    // k=1 tile: 4 LOAD + 8 COMPUTE + DONE
    add(0, 1, 0, 0, 1, z);
    add_load();
    for (int t = 0; t < 8; t++) add(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 1, 0, 0, f1[t], o1[t], 18'(t)));
    add(0, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, z);
    // reset mid-LOAD together with start
    add(0, 1, 0, 0, 2, z);
    add(0, 0, 0, 0, 0, ex(1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    add(1, 1, 0, 0, 2, ex(1, 0, 0, 1, 1, 1, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, z);
    add(0, 0, 0, 0, 0, z);

    bus.start = 1'b0;
    bus.k_len = '0;
    bus.hold  = 1'b0;
    bus.abort = 1'b0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst       = tbl[i].rst;
      bus.start = tbl[i].start;
      bus.hold  = tbl[i].hold;
      bus.abort = tbl[i].abort;
      bus.k_len = tbl[i].k;
      #1;
      check_vec($sformatf("vec%0d", i), act(), tbl[i].exp);
    end

    // k=5 with holds at cycles 3 and 10: done at 1+4+12+2 = 19, 20 feed and 20 out beats
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.k_len = 16'd5;
    bus.hold  = 1'b0;
    bus.abort = 1'b0;
    n    = 0;
    fsum = 0;
    osum = 0;
    for (int cyc = 1; cyc < 100; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.hold  = (cyc == 3 || cyc == 10);
      #1;
      if (bus.done) begin
        n = cyc;
        break;
      end
      fsum += $countones(bus.feed_mask);
      osum += $countones(bus.out_mask);
    end
    check_int("k5_done_cycle", n, 19);
    check_int("k5_feed_beats", fsum, 20);
    check_int("k5_out_beats", osum, 20);
    @(negedge clk);
    bus.hold = 1'b0;
    #1;
    check_int("k5_idle_after_done", int'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_array_sequencer.md
Name: systolic_array_sequencer

Overview:
Control FSM that runs one tile operation on the ARR_SIZE x ARR_SIZE MAC array. It preloads weights with the array in load mode, then streams activations in a diagonal skew. It flags which bottom-edge columns carry valid results each cycle, and reports busy/done to the host. Operand buffers and the result collector sit beside it and follow its enables and counters.

Parameters:
ARR_SIZE, 4, array dimension (rows = columns); must be >= 2
K_W, 16, width of tile reduction length k_len
CNT_W, K_W+2, width of internal/output step counter

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
start  input  1  start request; sampled only in IDLE
k_len  input  K_W  reduction length; latched on accepted start
hold  input  1  backpressure from result sink; freezes LOAD/COMPUTE progress
abort  input  1  synchronous abort; any state -> IDLE next cycle
busy  output  1  high in LOAD, COMPUTE, DONE
done  output  1  one-cycle pulse in DONE
err  output  1  one-cycle pulse when start is accepted with k_len==0
array_mode  output  1  drives array i_mode; 1 = weight load, 0 = compute
array_en  output  1  clock-enable to PE array and operand buffers
ld_en  output  1  weight row load strobe
ld_addr  output  $clog2(ARR_SIZE)  weight row index during LOAD
feed_mask  output  ARR_SIZE  bit r = row r left-edge input valid this cycle
out_mask  output  ARR_SIZE  bit c = column c bottom output valid this cycle
step  output  CNT_W  current COMPUTE step t; buffers index row r with t-r

Behaviour:
- Reset: state=IDLE. All outputs 0. k_len register and counters 0. Reset wins over abort, start and hold.
- IDLE:
  - start & k_len!=0: latch k_len, go to LOAD, counter=0.
  - start & k_len==0: err=1 for one cycle, stay in IDLE.
  - Otherwise stay.
- LOAD:
  - array_mode=1, ld_en=array_en=~hold, ld_addr=counter.
  - Counter increments only when ~hold.
  - At counter==ARR_SIZE-1 with ~hold: go to COMPUTE, counter=0.
  - Lasts exactly ARR_SIZE un-held cycles.
- COMPUTE:
  - array_mode=0, array_en=~hold, step=t (counter).
  - feed_mask[r] = ~hold & (r <= t < r+k_len).
  - out_mask[c] = ~hold & (ARR_SIZE+c <= t < ARR_SIZE+c+k_len).
  - t increments when ~hold.
  - At t==k_len+2*ARR_SIZE-2 with ~hold: go to DONE.
  - Total span is k_len+2*ARR_SIZE-1 un-held cycles.
  - All comparisons are unsigned at CNT_W bits; no wrap is possible for legal k_len.
- DONE: done=1, busy=1, array_en=0, then IDLE. start in DONE is ignored.
- hold:
  - While hold=1, the state and counter are frozen.
  - ld_en, feed_mask, out_mask and array_en are forced to 0.
  - step keeps its value.
  - Result: zero gaps in the skew, and no data is lost.
- abort: in any non-IDLE state, go to IDLE next cycle with all outputs 0 and no done pulse. abort in IDLE has no effect. abort together with start in IDLE: abort wins and start is dropped.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs except the hold gating of enables and masks.
- A new start can be accepted in the cycle after DONE (back-to-back tiles need 1 idle cycle).

Test Plan:
- ARR_SIZE=4, k_len=3, start at cycle 0:
  - LOAD cycles 1-4 with ld_addr 0,1,2,3 and array_mode=1.
  - COMPUTE cycles 5-14 (t=0..9).
  - feed_mask: 0001,0011,0111,1110,1100,1000 at t=0..5.
  - out_mask[0] at t=4-6, out_mask[3] at t=7-9.
  - done at cycle 15, busy low at cycle 16.
- Same run with hold=1 for cycles 7-9 (t=2): step stays 2, masks and array_en are 0 while held, then the sequence resumes unchanged. done moves to cycle 18.
- start with k_len=0: err pulses once, busy stays 0, no ld_en.
- abort at COMPUTE t=5: idle next cycle, all masks 0, no done pulse. A new start with k_len=1 then completes in 4+8+1 cycles.
- rst asserted mid-LOAD together with start: all outputs 0 next cycle, state IDLE, start ignored.
- k_len=1: each feed_mask[r] is high only at t=r; each out_mask[c] only at t=4+c. done after t=7.
